// File: rtl/iccm_arbiter.sv
// Shares the single-port ICCM macro between the core fetch port and the program loader,
// gating core fetches until the loader releases the core, and steering 1-cycle responses back.
module iccm_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      core_req_i,
    input  logic [ADDR_WIDTH-1:0]     core_addr_i,
    output logic                      core_gnt_o,
    output logic                      core_rvalid_o,
    output logic [DATA_WIDTH-1:0]     core_rdata_o,
    input  logic                      ld_req_i,
    input  logic                      ld_we_i,
    input  logic [ADDR_WIDTH-1:0]     ld_addr_i,
    input  logic [DATA_WIDTH-1:0]     ld_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   ld_wmask_i,
    output logic                      ld_gnt_o,
    output logic                      ld_rvalid_o,
    output logic [DATA_WIDTH-1:0]     ld_rdata_o,
    input  logic                      ld_done_i,
    input  logic                      ld_boot_i,
    output logic                      fetch_en_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   mem_wmask_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    input  logic                      mem_rvalid_i
);

    localparam int unsigned MASK_W = DATA_WIDTH / 8;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_fetch_en;
    logic   r_last_ld;
    logic   r_rd_pend;
    logic   r_owner_ld;
    logic   r_wack;
    logic   w_core_gnt;
    logic   w_ld_gnt;
    logic   w_contend;
    logic   w_rd_gnt;
    logic   w_rsp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_BOOT;
            r_fetch_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_en <= (w_state_nxt == ST_RUN);
        end
    end

    // Next state and grants; ld_boot_i has priority over ld_done_i.
    always_comb begin
        w_state_nxt = r_state;
        w_core_gnt  = 1'b0;
        w_ld_gnt    = 1'b0;
        w_contend   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_ld_gnt = ld_req_i;
                if (ld_done_i && !ld_boot_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_contend = core_req_i & ld_req_i;
                if (w_contend) begin
                    w_core_gnt = r_last_ld;
                    w_ld_gnt   = ~r_last_ld;
                end else begin
                    w_core_gnt = core_req_i;
                    w_ld_gnt   = ld_req_i;
                end
                if (ld_boot_i) begin
                    w_state_nxt = ST_BOOT;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (w_core_gnt) begin
            mem_addr_o = core_addr_i;
        end else if (w_ld_gnt) begin
            mem_we_o    = ld_we_i;
            mem_addr_o  = ld_addr_i;
            mem_wdata_o = ld_wdata_i;
            mem_wmask_o = ld_wmask_i;
        end
    end

    assign mem_req_o = w_core_gnt | w_ld_gnt;
    assign w_rd_gnt  = w_core_gnt | (w_ld_gnt & ~ld_we_i);

    // Read ownership, write-ack and round-robin history.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_pend  <= 1'b0;
            r_owner_ld <= 1'b0;
            r_wack     <= 1'b0;
            r_last_ld  <= 1'b1;
        end else begin
            if (w_rd_gnt) begin
                r_rd_pend  <= 1'b1;
                r_owner_ld <= w_ld_gnt;
            end else if (mem_rvalid_i) begin
                r_rd_pend <= 1'b0;
            end
            r_wack <= w_ld_gnt & ld_we_i;
            if (w_contend) begin
                r_last_ld <= w_ld_gnt;
            end
        end
    end

    // Responses without a pending read are dropped.
    assign w_rsp         = mem_rvalid_i & r_rd_pend;
    assign core_rvalid_o = w_rsp & ~r_owner_ld;
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : DATA_WIDTH'(0);
    assign ld_rvalid_o   = (w_rsp & r_owner_ld) | r_wack;
    assign ld_rdata_o    = (w_rsp & r_owner_ld) ? mem_rdata_i : DATA_WIDTH'(0);
    assign core_gnt_o    = w_core_gnt;
    assign ld_gnt_o      = w_ld_gnt;
    assign fetch_en_o    = r_fetch_en;

    initial begin : p_unused_param
    end

endmodule

// File: tb/tb_iccm_arbiter.sv
// Directed bench for iccm_arbiter: a macro model, a per-cycle reference model and
// hand-computed literal checks of the boot, arbitration and response behaviour.
module tb_iccm_arbiter;

    logic        clk;
    logic        rst_ni;
    logic        core_req;
    logic [11:0] core_addr;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        ld_req;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_wdata;
    logic [3:0]  ld_wmask;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        ld_done;
    logic        ld_boot;
    logic        fetch_en;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int n_cmp = 0;
    int n_err = 0;

    iccm_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_req_i(core_req), .core_addr_i(core_addr), .core_gnt_o(core_gnt),
        .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
        .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
        .ld_wmask_i(ld_wmask), .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
        .ld_done_i(ld_done), .ld_boot_i(ld_boot), .fetch_en_o(fetch_en),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Single-port macro: registered read data one cycle after a read request.
    logic [31:0] macro_mem [int];
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    end
    always @(posedge clk) begin
        logic [31:0] old;
        old = macro_mem.exists(int'(mem_addr)) ? macro_mem[int'(mem_addr)] : 32'h0;
        mem_rvalid <= mem_req & ~mem_we;
        if (mem_req && !mem_we) mem_rdata <= old;
        if (mem_req && mem_we) macro_mem[int'(mem_addr)] = merge(old, mem_wdata, mem_wmask);
    end

    // Reference model: golden image, run flag, last tie winner, next expected response.
    logic [31:0] gold [int];
    bit          m_run = 0;
    bit          m_last_ld = 1;
    int          m_rk = 0;      // 0 none, 1 core data, 2 loader data, 3 loader write ack
    logic [31:0] m_rd = '0;

    always @(negedge clk) begin
        bit cg, lg;
        logic [31:0] g;
        if (!rst_ni) begin
            m_run = 0; m_last_ld = 1; m_rk = 0;
            chk("rst_core_gnt", 32'(core_gnt), 0);
            chk("rst_core_rvalid", 32'(core_rvalid), 0);
            chk("rst_ld_rvalid", 32'(ld_rvalid), 0);
            chk("rst_fetch_en", 32'(fetch_en), 0);
            chk("rst_mem_req", 32'(mem_req), 32'(ld_req));
        end else begin
            if (!m_run) begin
                cg = 0; lg = ld_req;
            end else if (core_req && ld_req) begin
                cg = m_last_ld; lg = !m_last_ld;
            end else begin
                cg = core_req; lg = ld_req;
            end
            chk("core_gnt", 32'(core_gnt), 32'(cg));
            chk("ld_gnt", 32'(ld_gnt), 32'(lg));
            chk("mem_req", 32'(mem_req), 32'(cg | lg));
            chk("mem_we", 32'(mem_we), 32'(lg & ld_we));
            chk("mem_wmask", 32'(mem_wmask), (lg & ld_we) ? 32'(ld_wmask) : 0);
            if (cg | lg) chk("mem_addr", 32'(mem_addr), cg ? 32'(core_addr) : 32'(ld_addr));
            if (lg & ld_we) chk("mem_wdata", mem_wdata, ld_wdata);
            chk("fetch_en", 32'(fetch_en), 32'(m_run));
            chk("core_rvalid", 32'(core_rvalid), 32'(m_rk == 1));
            chk("core_rdata", core_rdata, (m_rk == 1) ? m_rd : 0);
            chk("ld_rvalid", 32'(ld_rvalid), 32'(m_rk == 2 || m_rk == 3));
            chk("ld_rdata", ld_rdata, (m_rk == 2) ? m_rd : 0);
            m_rk = 0;
            if (cg) begin
                m_rk = 1;
                m_rd = gold.exists(int'(core_addr)) ? gold[int'(core_addr)] : 32'h0;
            end else if (lg) begin
                g = gold.exists(int'(ld_addr)) ? gold[int'(ld_addr)] : 32'h0;
                if (ld_we) begin
                    m_rk = 3;
                    gold[int'(ld_addr)] = merge(g, ld_wdata, ld_wmask);
                end else begin
                    m_rk = 2;
                    m_rd = g;
                end
            end
            if (m_run && core_req && ld_req) m_last_ld = lg;
            if (ld_boot) m_run = 0;
            else if (ld_done) m_run = 1;
        end
    end

    task automatic settle();
        @(negedge clk); #1;
    endtask
    task automatic nxt();
        @(posedge clk); #1;
    endtask
    task automatic ld_drive(input bit req, input bit we, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        ld_req = req; ld_we = we; ld_addr = a; ld_wdata = d; ld_wmask = m;
    endtask

    initial begin
        rst_ni = 0; core_req = 0; core_addr = '0; ld_done = 0; ld_boot = 0;
        ld_drive(0, 0, 0, 0, 0);
        repeat (2) begin settle(); nxt(); end
        rst_ni = 1;

        // Boot gating and first write/read through.
        core_req = 1; core_addr = 12'h010;
        ld_drive(1, 1, 12'h010, 32'hDEADBEEF, 4'hF);
        settle(); chk("boot_core_gnt", 32'(core_gnt), 0); chk("boot_ld_gnt", 32'(ld_gnt), 1); nxt();
        ld_drive(0, 0, 0, 0, 0); ld_done = 1;
        settle(); chk("wack_valid", 32'(ld_rvalid), 1); chk("wack_data", ld_rdata, 0);
        chk("boot_fetch_en", 32'(fetch_en), 0); nxt();
        ld_done = 0;
        settle(); chk("run_fetch_en", 32'(fetch_en), 1); chk("run_core_gnt", 32'(core_gnt), 1); nxt();
        core_req = 0;
        settle(); chk("first_fetch_v", 32'(core_rvalid), 1); chk("first_fetch_d", core_rdata, 32'hDEADBEEF); nxt();

        // Round-robin between two continuous readers.
        ld_drive(1, 1, 12'h020, 32'hCAFEF00D, 4'hF); settle(); nxt();
        ld_drive(0, 0, 0, 0, 0); settle(); nxt();
        core_req = 1; core_addr = 12'h010; ld_drive(1, 0, 12'h020, 0, 0);
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("rr_core_gnt", 32'(core_gnt), 32'(i % 2 == 0));
            chk("rr_ld_gnt", 32'(ld_gnt), 32'(i % 2 == 1));
            if (i > 0) begin
                chk("rr_core_rv", 32'(core_rvalid), 32'(i % 2 == 1));
                chk("rr_ld_rv", 32'(ld_rvalid), 32'(i % 2 == 0));
            end
            nxt();
        end
        core_req = 0; ld_drive(0, 0, 0, 0, 0);
        settle(); chk("rr_last_ld_d", ld_rdata, 32'hCAFEF00D); chk("rr_last_core_rv", 32'(core_rvalid), 0); nxt();

        // Back-to-back core reads.
        for (int i = 0; i < 4; i++) begin
            ld_drive(1, 1, 12'(i), 32'hA0000000 + 32'(i), 4'hF); settle(); nxt();
        end
        ld_drive(0, 0, 0, 0, 0); settle(); nxt();
        for (int i = 0; i < 4; i++) begin
            core_req = 1; core_addr = 12'(i);
            settle();
            chk("b2b_gnt", 32'(core_gnt), 1);
            if (i > 0) begin
                chk("b2b_data", core_rdata, 32'hA0000000 + 32'(i - 1));
                chk("b2b_ld_rv", 32'(ld_rvalid), 0);
            end
            nxt();
        end
        core_req = 0;
        settle(); chk("b2b_last", core_rdata, 32'hA0000003); nxt();

        // Byte-masked write then read-after-write.
        ld_drive(1, 1, 12'h030, 32'h11223344, 4'hF); settle(); nxt();
        ld_drive(1, 1, 12'h030, 32'h000000AA, 4'h1); settle(); nxt();
        ld_drive(1, 0, 12'h030, 0, 0);
        settle(); chk("mask_wack", 32'(ld_rvalid), 1); chk("mask_wack_d", ld_rdata, 0); nxt();
        ld_drive(0, 0, 0, 0, 0);
        settle(); chk("mask_rv", 32'(ld_rvalid), 1); chk("mask_data", ld_rdata, 32'h112233AA); nxt();

        // Reprogram with a core read in flight.
        core_req = 1; core_addr = 12'h010; ld_boot = 1;
        settle(); chk("reprog_gnt", 32'(core_gnt), 1); nxt();
        ld_boot = 0; core_addr = 12'h011;
        settle(); chk("reprog_rv", 32'(core_rvalid), 1); chk("reprog_d", core_rdata, 32'hDEADBEEF);
        chk("reprog_no_gnt", 32'(core_gnt), 0); chk("reprog_fetch_en", 32'(fetch_en), 0); nxt();
        ld_done = 1; ld_boot = 1; settle(); nxt();
        ld_done = 0; ld_boot = 0;
        settle(); chk("both_pulse_en", 32'(fetch_en), 0); chk("both_pulse_gnt", 32'(core_gnt), 0); nxt();
        ld_done = 1; settle(); chk("done_cycle_gnt", 32'(core_gnt), 0); nxt();
        ld_done = 0; settle(); chk("rerun_gnt", 32'(core_gnt), 1); nxt();
        core_req = 0; settle(); chk("rerun_rv", 32'(core_rvalid), 1); chk("rerun_d", core_rdata, 0); nxt();

        // Asynchronous reset with a loader read outstanding.
        ld_drive(1, 0, 12'h010, 0, 0);
        settle(); chk("ar_gnt", 32'(ld_gnt), 1); nxt();
        ld_drive(0, 0, 0, 0, 0); rst_ni = 0;
        settle(); chk("ar_ld_rv", 32'(ld_rvalid), 0); chk("ar_fetch_en", 32'(fetch_en), 0); nxt();
        settle(); nxt();
        rst_ni = 1; core_req = 1; core_addr = 12'h000;
        settle(); chk("ar_boot_gnt", 32'(core_gnt), 0); nxt();
        core_req = 0;
        repeat (3) begin
            settle(); chk("ar_no_ld_rv", 32'(ld_rvalid), 0); chk("ar_no_core_rv", 32'(core_rvalid), 0); nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iccm_arbiter.md
# iccm_arbiter

Two-port arbiter and boot sequencer in front of the single-port instruction memory (ICCM) macro wrapper. It shares the macro between the core's instruction-fetch port (read-only) and a program-loader port (read/write, driven by the boot/debug loader). It holds the core off until the loader signals that the image is in place, and routes the macro's 1-cycle read responses back to whichever requester issued them.

## Interface
Parameters:
- ADDR_WIDTH, 12, word address width of the ICCM.
- DATA_WIDTH, 32, data width. Byte-mask width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock. Single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- core_req_i  in  1  fetch request.
- core_addr_i  in  ADDR_WIDTH  fetch word address.
- core_gnt_o  out  1  fetch accepted this cycle. Combinational.
- core_rvalid_o  out  1  fetch data valid.
- core_rdata_o  out  DATA_WIDTH  fetch data.
- ld_req_i  in  1  loader request.
- ld_we_i  in  1  loader write enable.
- ld_addr_i  in  ADDR_WIDTH  loader word address.
- ld_wdata_i  in  DATA_WIDTH  loader write data.
- ld_wmask_i  in  DATA_WIDTH/8  loader byte mask.
- ld_gnt_o  out  1  loader request accepted. Combinational.
- ld_rvalid_o  out  1  loader response: read data, or write acknowledge.
- ld_rdata_o  out  DATA_WIDTH  loader read data. Zero on a write ack.
- ld_done_i  in  1  pulse: image loaded, release the core.
- ld_boot_i  in  1  pulse: re-enter boot (reprogram) mode.
- fetch_en_o  out  1  high in RUN state.
- mem_req_o, mem_we_o  out  1  macro request and write enable.
- mem_addr_o  out  ADDR_WIDTH  macro address.
- mem_wdata_o  out  DATA_WIDTH  macro write data.
- mem_wmask_o  out  DATA_WIDTH/8  macro byte mask.
- mem_rdata_i  in  DATA_WIDTH  macro read data.
- mem_rvalid_i  in  1  macro read valid, one cycle after a read request.

## Operation
- FSM: BOOT (reset state) and RUN.
  - BOOT -> RUN on ld_done_i.
  - RUN -> BOOT on ld_boot_i.
  - If both pulses are high together, ld_boot_i wins.
- BOOT state:
  - core_gnt_o=0.
  - ld_gnt_o=ld_req_i.
  - fetch_en_o=0.
- RUN state, when only one requester is asking, that requester is granted.
- RUN state, when both ask, round-robin:
  - The grant goes to the requester not granted last.
  - Last-winner flop resets to LOADER, so the core wins the first tie.
  - The flop updates only on a contended grant.
- Mux: mem_req_o = OR of the grants, and the granted port's address, data, mask and we drive the macro.
  - The core port always drives we=0, wmask=0.
  - With no grant, mem_we_o=0 and mem_wmask_o=0.
- Response tracking:
  - On a granted read, set rd_pend_q=1 and record owner_q (CORE or LD).
  - On mem_rvalid_i, forward mem_rdata_i combinationally to the owner's rvalid/rdata, and clear rd_pend_q unless a new read was granted in the same cycle.
  - A mem_rvalid_i that arrives with rd_pend_q=0 is dropped.
- Write acknowledge: a granted loader write sets wack_q. The next cycle, ld_rvalid_o=1 with ld_rdata_o=0. The macro gives no write response.
- Switching RUN -> BOOT:
  - An already granted core read still returns its data on core_rvalid_o.
  - No new core grants are issued.

## Timing
- Grant is combinational in the request cycle N. The response (rvalid) arrives in N+1. Issue rate is one per cycle, back-to-back.
- Read-after-write to the same address in N+1 returns the new data.
- Reset values (asynchronous):
  - state=BOOT, rd_pend_q=0, wack_q=0, last-winner=LOADER.
  - core_rvalid_o=0, ld_rvalid_o=0, fetch_en_o=0.
  - With no requests, grants=0 and mem_req_o=0.
- Reset asserted mid-transaction: the pending response is discarded, and no rvalid appears after reset release.
- fetch_en_o is registered from state and goes high in the cycle after the ld_done_i cycle. Core grants are possible from that same cycle.
- Requesters hold req/addr until gnt. Dropping req before gnt is legal and cancels the request.

## Test plan
- Boot gating: reset, core_req_i=1 at addr 0x010 → core_gnt_o stays 0. Loader writes 0xDEADBEEF to 0x010 (wmask 0xF) → ld_gnt_o same cycle, then ld_rvalid_o=1 with ld_rdata_o=0 next cycle. Pulse ld_done_i → fetch_en_o=1 next cycle, core granted, and core_rdata_o=0xDEADBEEF one cycle after the grant.
- Round-robin: in RUN, both ports read continuously for 6 cycles → grants alternate CORE, LD, CORE, LD… Each rvalid reaches only its owner with the correct data.
- Back-to-back: core reads 0x000–0x003 on consecutive cycles → four consecutive core_rvalid_o pulses with in-order data. ld_rvalid_o stays 0.
- Byte mask: word 0x11223344, loader writes 0x000000AA with mask 0x1, then reads back → 0x112233AA.
- Reprogram: in RUN, a core read is granted in the same cycle as an ld_boot_i pulse → that read still returns core_rvalid_o. Later core requests get no grant until the next ld_done_i.
- Async reset: assert rst_ni low in the cycle after a loader read grant → ld_rvalid_o=0 immediately, state=BOOT, and no stray rvalid after release.
